// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//   Latches one intensity vector per frame and issues start to the SNN core.
//   It then answers each sample handshake with a rate-coded spike vector,
//   for N_STEPS timesteps.
//   Build option: define SPIKE_ENC_ACCUM_EN to replace the LFSR rate coder
//   with deterministic per-channel accumulators. Ports, FSM and handshake
//   timing are the same in both builds.
`timescale 1ns/1ps

module spike_rate_encoder #(
  parameter int          N_IN       = 4,
  parameter int          VAL_W      = 8,
  parameter int          N_STEPS    = 10,
  parameter int          STEP_CNT_W = 5,
  parameter logic [31:0] LFSR_SEED  = 32'hACE11234
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [N_IN*VAL_W-1:0]   i_in_values,
  input  logic                    i_net_ready,
  output logic                    o_start,
  input  logic                    i_sample,
  output logic                    o_sample_ready,
  output logic [N_IN-1:0]         o_spikes,
  output logic                    o_busy,
  output logic                    o_frame_done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(N_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT_NET, S_RUN} state_t;

  state_t                  r_state;
  logic [STEP_CNT_W-1:0]   r_step_cnt;
  logic [N_IN*VAL_W-1:0]   r_intensity;
  logic [N_IN-1:0]         r_spikes;
  logic                    r_sample_ready;
  logic                    r_frame_done;

  logic                    w_accept;
  logic                    w_gen;
  logic [N_IN-1:0]         w_gen_spikes;

  // Load a new frame only from IDLE.
  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  // A new vector is produced in GEN and on every non-final consumed sample.
  assign w_gen = (r_state == S_GEN) ||
                 ((r_state == S_RUN) && i_sample && (r_step_cnt != LAST_STEP));

  genvar gi, gj;

`ifdef SPIKE_ENC_ACCUM_EN
  logic [N_IN*VAL_W-1:0] r_acc;
  logic [N_IN*VAL_W-1:0] w_acc_next;

  for (gi = 0; gi < N_IN; gi++) begin : g_accum
    logic [VAL_W:0] w_sum;
    assign w_sum = {1'b0, r_acc[gi*VAL_W +: VAL_W]} + {1'b0, r_intensity[gi*VAL_W +: VAL_W]};
    assign w_acc_next[gi*VAL_W +: VAL_W] = w_sum[VAL_W-1:0];
    // The carry out of the accumulator is the spike; full scale always fires.
    assign w_gen_spikes[gi] = w_sum[VAL_W] | (&r_intensity[gi*VAL_W +: VAL_W]);
  end

  // Accumulators restart from zero on every frame load and step per vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (w_gen) begin
      r_acc <= w_acc_next;
    end
  end
`else
  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_next;

  // Galois form: shift right, fold taps in when the bit shifted out is 1.
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  for (gi = 0; gi < N_IN; gi++) begin : g_rate
    localparam int ROT = (7 * gi) % 32;
    logic [VAL_W-1:0] w_rand;
    // Low VAL_W bits of the LFSR rotated left by 7*i; each channel sees a
    // different slice of the same state word.
    for (gj = 0; gj < VAL_W; gj++) begin : g_bit
      assign w_rand[gj] = r_lfsr[(gj + 32 - ROT) % 32];
    end
    assign w_gen_spikes[gi] = (w_rand < r_intensity[gi*VAL_W +: VAL_W]) |
                              (&r_intensity[gi*VAL_W +: VAL_W]);
  end

  // LFSR reloads the seed on frame load and advances once per vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (w_accept) begin
      r_lfsr <= SEED;
    end else if (w_gen) begin
      r_lfsr <= w_lfsr_next;
    end
  end
`endif

  // Frame FSM: IDLE -> GEN -> WAIT_NET -> RUN -> IDLE, with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_step_cnt     <= '0;
      r_intensity    <= '0;
      r_spikes       <= '0;
      r_sample_ready <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_intensity <= i_in_values;
            r_step_cnt  <= '0;
            r_state     <= S_GEN;
          end
        end
        S_GEN: begin
          r_spikes <= w_gen_spikes;
          r_state  <= S_WAIT_NET;
        end
        S_WAIT_NET: begin
          if (i_net_ready) begin
            r_sample_ready <= 1'b1;
            r_state        <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_sample) begin
            r_step_cnt <= r_step_cnt + 1'b1;
            if (r_step_cnt == LAST_STEP) begin
              r_sample_ready <= 1'b0;
              r_spikes       <= '0;
              r_frame_done   <= 1'b1;
              r_state        <= S_IDLE;
            end else begin
              r_spikes <= w_gen_spikes;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // start is asserted in the very WAIT_NET cycle that sees net_ready, so the
  // network starts two cycles after the vector is accepted.
  assign o_start        = (r_state == S_WAIT_NET) && i_net_ready;
  assign o_in_ready     = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_sample_ready = r_sample_ready;
  assign o_spikes       = r_spikes;
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder
//   Scoreboard bench: expected spike vectors for a whole frame are pushed when
//   the frame is offered and popped as each sample is consumed.
//   Build option: define SPIKE_ENC_ACCUM_EN for both files to use the
//   accumulator reference instead of the LFSR reference.
`timescale 1ns/1ps

module tb_spike_rate_encoder;
  localparam int N_IN    = 4;
  localparam int VAL_W   = 8;
  localparam int N_STEPS = 10;
  localparam logic [31:0] SEED = 32'hACE11234;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_in_valid = 1'b0;
  logic                  o_in_ready;
  logic [N_IN*VAL_W-1:0] i_in_values = '0;
  logic                  i_net_ready = 1'b0;
  logic                  o_start;
  logic                  i_sample = 1'b0;
  logic                  o_sample_ready;
  logic [N_IN-1:0]       o_spikes;
  logic                  o_busy;
  logic                  o_frame_done;

  always #5 clk = ~clk;

  spike_rate_encoder #(
    .N_IN(N_IN), .VAL_W(VAL_W), .N_STEPS(N_STEPS), .STEP_CNT_W(5), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_values(i_in_values),
    .i_net_ready(i_net_ready), .o_start(o_start),
    .i_sample(i_sample), .o_sample_ready(o_sample_ready), .o_spikes(o_spikes),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [N_IN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ TAPS;
    return y;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    logic [31:0] y;
    y = x;
    for (int k = 0; k < s; k++) y = {y[30:0], y[31]};
    return y;
  endfunction

  // Reference encoder: build the whole frame's vectors and queue them.
  task automatic push_frame_expect(input logic [N_IN*VAL_W-1:0] vals);
    logic [31:0]     lfsr;
    logic [31:0]     rr;
    logic [7:0]      r8;
    logic [7:0]      v;
    int              acc[N_IN];
    int              sum;
    logic [N_IN-1:0] vec;
    lfsr = SEED;
    for (int ch = 0; ch < N_IN; ch++) acc[ch] = 0;
    for (int st = 0; st < N_STEPS; st++) begin
      for (int ch = 0; ch < N_IN; ch++) begin
        v = vals[ch*VAL_W +: VAL_W];
`ifdef SPIKE_ENC_ACCUM_EN
        sum = acc[ch] + int'(v);
        vec[ch] = (sum >= 256) || (v == 8'hFF);
        acc[ch] = sum % 256;
`else
        sum = 0;
        rr = rotl(lfsr, 7 * ch);
        r8 = rr[7:0];
        vec[ch] = (r8 < v) || (v == 8'hFF);
`endif
      end
      lfsr = lfsr_step(lfsr);
      exp_q.push_back(vec);
    end
  endtask

  // One frame: accept, optional net_ready delay, samples with optional gaps,
  // optional asynchronous reset after abort_after samples.
  task automatic run_frame(input logic [N_IN*VAL_W-1:0] vals, input int net_delay,
                           input int gap, input int abort_after);
    int guard;
    logic [N_IN-1:0] exp_vec;
    guard = 0;
    while (!o_in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("in_ready_before_accept", 32'(o_in_ready), 1);
    i_in_values = vals;
    i_in_valid  = 1'b1;
    i_net_ready = (net_delay == 0);
    push_frame_expect(vals);
    @(posedge clk); #1;
    // GEN cycle: new in_valid and sample must be ignored.
    i_in_values = $urandom;
    i_sample    = 1'b1;
    check_eq("gen_start_low", 32'(o_start), 0);
    check_eq("gen_in_ready_low", 32'(o_in_ready), 0);
    check_eq("gen_busy", 32'(o_busy), 1);
    @(posedge clk); #1;
    for (int d = 0; d < net_delay; d++) begin
      i_sample = d[0];
      check_eq("wait_start_low", 32'(o_start), 0);
      check_eq("wait_in_ready_low", 32'(o_in_ready), 0);
      check_eq("wait_sample_ready_low", 32'(o_sample_ready), 0);
      @(posedge clk); #1;
    end
    i_in_valid  = 1'b0;
    i_sample    = 1'b0;
    i_net_ready = 1'b1;
    #1;
    check_eq("start_pulse", 32'(o_start), 1);
    @(posedge clk); #1;
    check_eq("start_one_cycle", 32'(o_start), 0);
    check_eq("run_sample_ready", 32'(o_sample_ready), 1);
    i_net_ready = 1'($urandom_range(0, 1));
    for (int k = 0; k < N_STEPS; k++) begin
      if (k == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_sample_ready", 32'(o_sample_ready), 0);
        check_eq("rst_spikes", 32'(o_spikes), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_in_ready", 32'(o_in_ready), 1);
        check_eq("rst_start", 32'(o_start), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        i_net_ready = 1'b0;
        $display("frame aborted by reset after %0d samples", k);
        exp_q.delete();
        return;
      end
      for (int g = 0; g < gap; g++) begin
        i_sample = 1'b0;
        @(posedge clk); #1;
        check_eq("gap_sample_ready", 32'(o_sample_ready), 1);
      end
      check_eq("sample_ready", 32'(o_sample_ready), 1);
      check_eq("queue_depth", 32'(exp_q.size()), 32'(N_STEPS - k));
      exp_vec = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq("spikes", 32'(o_spikes), 32'(exp_vec));
      $display("sample %0d: vals=%h spikes=%h expected=%h", k, vals, o_spikes, exp_vec);
      i_sample = 1'b1;
      @(posedge clk); #1;
      i_sample = 1'b0;
    end
    check_eq("frame_done_pulse", 32'(o_frame_done), 1);
    check_eq("end_sample_ready_low", 32'(o_sample_ready), 0);
    check_eq("end_spikes_zero", 32'(o_spikes), 0);
    check_eq("end_busy_low", 32'(o_busy), 0);
    check_eq("end_in_ready", 32'(o_in_ready), 1);
    i_net_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("frame_done_one_cycle", 32'(o_frame_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1);
  end

  initial begin
    logic [N_IN*VAL_W-1:0] rnd_vals;
    // Reset with random inputs toggling.
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_in_valid  = 1'($urandom_range(0, 1));
      i_in_values = $urandom;
      i_net_ready = 1'($urandom_range(0, 1));
      i_sample    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("reset_start", 32'(o_start), 0);
      check_eq("reset_sample_ready", 32'(o_sample_ready), 0);
      check_eq("reset_spikes", 32'(o_spikes), 0);
      check_eq("reset_busy", 32'(o_busy), 0);
      check_eq("reset_in_ready", 32'(o_in_ready), 1);
    end
    i_in_valid  = 1'b0;
    i_net_ready = 1'b0;
    i_sample    = 1'b0;
    rst_n       = 1'b1;
    @(posedge clk); #1;

    run_frame(32'hFFFFFFFF, 0, 0, -1);
    run_frame(32'h00000000, 0, 0, -1);
    run_frame(32'h80808080, 0, 0, -1);
    run_frame(32'h40404040, 0, 0, -1);
    run_frame(32'hFF004080, 0, 1, -1);
    rnd_vals = $urandom;
    run_frame(rnd_vals, 20, 0, -1);
    rnd_vals = $urandom;
    run_frame(rnd_vals, 0, 0, 5);
    run_frame(rnd_vals, 0, 0, -1);
    rnd_vals = $urandom;
    run_frame(rnd_vals, 3, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
